// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared constants and helpers for the UART RX front-end blocks.
//   PRESCALE_8/16/32   : legal oversampling ratios
//   BIT_CNT_START      : bit index of the start bit
//   BIT_CNT_LAST_DATA  : bit index of the last data bit
//   maj3()             : 3-input majority vote
//   prescale_is_legal(): true for one of the supported oversampling ratios
// -----------------------------------------------------------------------------
package rx_pkg;

  localparam int unsigned PRESCALE_8        = 32'd8;
  localparam int unsigned PRESCALE_16       = 32'd16;
  localparam int unsigned PRESCALE_32       = 32'd32;

  localparam int unsigned BIT_CNT_START     = 32'd0;
  localparam int unsigned BIT_CNT_LAST_DATA = 32'd8;

  // Majority of three samples; tolerates one corrupted sample around the centre.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Helper for control logic that wants to qualify a prescale setting.
  function automatic logic prescale_is_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchroniser for a single asynchronous level. Both flops reset to 1
// so an idle-high serial line does not produce a false edge out of reset.
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronised output, 2 clk latency
// -----------------------------------------------------------------------------
module bit_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage shift register; first stage may go metastable, second resolves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// rx_bit_sampler
// UART RX front end: synchronises the serial line, tracks the oversample edge
// and bit position within a frame, and majority-votes three samples around the
// centre of each bit.
// Ports:
//   clk          : system clock (rising edge)
//   reset_n      : asynchronous active-low reset
//   rx_in        : raw serial line, asynchronous, idle high
//   prescale     : oversampling ratio (8, 16 or 32)
//   cnt_en       : high while the RX FSM is receiving a frame
//   edge_cnt     : oversample edge index within the current bit
//   bit_cnt      : bit index within the frame (0 = start bit), saturating
//   sampled_bit  : majority-voted value of the current bit
//   sample_valid : one-cycle pulse at edge mid+3, bit_cnt still on that bit
//   rx_sync      : synchronised rx_in for start-edge detection
// -----------------------------------------------------------------------------
module rx_bit_sampler
  import rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cnt_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  rx_sync
);

  localparam logic [PRESCALE_W-1:0] EDGE_ZERO = PRESCALE_W'(32'd0);
  localparam logic [PRESCALE_W-1:0] EDGE_ONE  = PRESCALE_W'(32'd1);
  localparam logic [PRESCALE_W-1:0] EDGE_TWO  = PRESCALE_W'(32'd2);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(32'd1);
  localparam logic [BIT_CNT_W-1:0]  BIT_START = BIT_CNT_W'(BIT_CNT_START);
  localparam logic [BIT_CNT_W-1:0]  BIT_MAX   = {BIT_CNT_W{1'b1}};

  logic                  rx_sync_s;
  logic [PRESCALE_W-1:0] mid_s;
  logic [PRESCALE_W-1:0] mid_m1_s;
  logic [PRESCALE_W-1:0] mid_p1_s;
  logic [PRESCALE_W-1:0] mid_p2_s;
  logic [PRESCALE_W-1:0] last_edge_s;

  logic [PRESCALE_W-1:0] edge_cnt_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic                  s0_r;
  logic                  s1_r;
  logic                  s2_r;
  logic                  sampled_bit_r;
  logic                  sample_valid_r;

  logic [PRESCALE_W-1:0] edge_cnt_nxt_s;
  logic [BIT_CNT_W-1:0]  bit_cnt_nxt_s;
  logic                  s0_nxt_s;
  logic                  s1_nxt_s;
  logic                  s2_nxt_s;
  logic                  sampled_bit_nxt_s;
  logic                  sample_valid_nxt_s;

  bit_sync u_bit_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_in),
    .q       (rx_sync_s)
  );

  assign mid_s       = prescale >> 1'b1;
  assign mid_m1_s    = mid_s - EDGE_ONE;
  assign mid_p1_s    = mid_s + EDGE_ONE;
  assign mid_p2_s    = mid_s + EDGE_TWO;
  assign last_edge_s = prescale - EDGE_ONE;

  // Next-state for counters, vote samples and the registered sample outputs.
  always_comb begin
    edge_cnt_nxt_s     = edge_cnt_r;
    bit_cnt_nxt_s      = bit_cnt_r;
    s0_nxt_s           = s0_r;
    s1_nxt_s           = s1_r;
    s2_nxt_s           = s2_r;
    sampled_bit_nxt_s  = sampled_bit_r;
    sample_valid_nxt_s = 1'b0;

    if (!cnt_en) begin
      // Idle: restart at edge 0 / bit 0 and drop any partial vote.
      edge_cnt_nxt_s = EDGE_ZERO;
      bit_cnt_nxt_s  = BIT_START;
      s0_nxt_s       = 1'b0;
      s1_nxt_s       = 1'b0;
      s2_nxt_s       = 1'b0;
    end else begin
      if (edge_cnt_r == last_edge_s) begin
        edge_cnt_nxt_s = EDGE_ZERO;
        if (bit_cnt_r != BIT_MAX) begin
          bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end else begin
        edge_cnt_nxt_s = edge_cnt_r + EDGE_ONE;
        bit_cnt_nxt_s  = bit_cnt_r;
      end

      if (edge_cnt_r == mid_m1_s) begin
        s0_nxt_s = rx_sync_s;
      end else begin
        s0_nxt_s = s0_r;
      end

      if (edge_cnt_r == mid_s) begin
        s1_nxt_s = rx_sync_s;
      end else begin
        s1_nxt_s = s1_r;
      end

      if (edge_cnt_r == mid_p1_s) begin
        s2_nxt_s = rx_sync_s;
      end else begin
        s2_nxt_s = s2_r;
      end

      // Registering here makes the pulse visible at edge mid+3, still inside
      // the bit, so the deserializer sees the matching bit_cnt.
      if (edge_cnt_r == mid_p2_s) begin
        sampled_bit_nxt_s  = maj3(s0_r, s1_r, s2_r);
        sample_valid_nxt_s = 1'b1;
      end else begin
        sampled_bit_nxt_s  = sampled_bit_r;
        sample_valid_nxt_s = 1'b0;
      end
    end
  end

  // State registers for counters, vote samples and sample outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt_r     <= EDGE_ZERO;
      bit_cnt_r      <= BIT_START;
      s0_r           <= 1'b0;
      s1_r           <= 1'b0;
      s2_r           <= 1'b0;
      sampled_bit_r  <= 1'b1;
      sample_valid_r <= 1'b0;
    end else begin
      edge_cnt_r     <= edge_cnt_nxt_s;
      bit_cnt_r      <= bit_cnt_nxt_s;
      s0_r           <= s0_nxt_s;
      s1_r           <= s1_nxt_s;
      s2_r           <= s2_nxt_s;
      sampled_bit_r  <= sampled_bit_nxt_s;
      sample_valid_r <= sample_valid_nxt_s;
    end
  end

  assign edge_cnt     = edge_cnt_r;
  assign bit_cnt      = bit_cnt_r;
  assign sampled_bit  = sampled_bit_r;
  assign sample_valid = sample_valid_r;
  assign rx_sync      = rx_sync_s;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// tb_rx_bit_sampler
// Directed self-checking bench for rx_bit_sampler. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge. rx_in reaches
// rx_sync two cycles after it is driven, which the glitch timings account for.
// -----------------------------------------------------------------------------
module tb_rx_bit_sampler;

  logic       clk;
  logic       reset_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       cnt_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;
  logic       rx_sync;

  int tests;
  int fails;

  rx_bit_sampler #(
    .PRESCALE_W (6),
    .BIT_CNT_W  (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .cnt_en       (cnt_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .rx_sync      (rx_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bit (or its first n_edges edges) and check every edge of it.
  // Bits g_start..g_start+g_len-1 of rx_in are driven inverted as a glitch.
  task automatic run_bit(input string tag, input int ps, input int bidx,
                         input logic val, input logic exp_bit,
                         input int g_start, input int g_len, input int n_edges);
    int mid;
    mid = ps / 2;
    for (int e = 0; e < n_edges; e++) begin
      chk($sformatf("%s b%0d e%0d edge_cnt", tag, bidx, e), {26'd0, edge_cnt}, e);
      chk($sformatf("%s b%0d e%0d bit_cnt", tag, bidx, e), {28'd0, bit_cnt}, bidx);
      chk($sformatf("%s b%0d e%0d sample_valid", tag, bidx, e), {31'd0, sample_valid},
          {31'd0, (e == mid + 3)});
      if (e == mid + 3) begin
        chk($sformatf("%s b%0d sampled_bit", tag, bidx), {31'd0, sampled_bit}, {31'd0, exp_bit});
      end
      rx_in = ((e >= g_start) && (e < g_start + g_len)) ? ~val : val;
      tick();
    end
  endtask

  logic t2_bits [10];
  logic t6_bits [4];

  initial begin
    tests    = 0;
    fails    = 0;
    reset_n  = 1'b0;
    rx_in    = 1'b1;
    cnt_en   = 1'b0;
    prescale = 6'd8;
    t2_bits  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    t6_bits  = '{1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: idle after reset
    repeat (20) tick();
    chk("t1 edge_cnt", {26'd0, edge_cnt}, 32'd0);
    chk("t1 bit_cnt", {28'd0, bit_cnt}, 32'd0);
    chk("t1 sampled_bit", {31'd0, sampled_bit}, 32'd1);
    chk("t1 sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("t1 rx_sync", {31'd0, rx_sync}, 32'd1);

    // 2: prescale 8, start + 0xA5 LSB-first + stop
    cnt_en = 1'b1;
    for (int b = 0; b < 10; b++) begin
      run_bit("t2", 8, b, t2_bits[b], t2_bits[b], 0, 0, 8);
    end
    chk("t2 end bit_cnt", {28'd0, bit_cnt}, 32'd10);
    chk("t2 end edge_cnt", {26'd0, edge_cnt}, 32'd0);
    cnt_en = 1'b0;
    tick();
    chk("t2 off edge_cnt", {26'd0, edge_cnt}, 32'd0);
    chk("t2 off bit_cnt", {28'd0, bit_cnt}, 32'd0);
    chk("t2 off sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("t2 off sampled_bit hold", {31'd0, sampled_bit}, 32'd1);

    // 3: prescale 16, one-clk glitch on the centre sample, then two-clk glitch
    prescale = 6'd16;
    rx_in    = 1'b1;
    repeat (4) tick();
    cnt_en = 1'b1;
    run_bit("t3 start", 16, 0, 1'b0, 1'b0, 0, 0, 16);
    run_bit("t3 glitch1", 16, 1, 1'b1, 1'b1, 6, 1, 16);
    run_bit("t3 glitch2", 16, 2, 1'b0, 1'b1, 5, 2, 16);
    run_bit("t3 clean", 16, 3, 1'b1, 1'b1, 0, 0, 16);
    cnt_en = 1'b0;
    rx_in  = 1'b1;
    tick();

    // 4: prescale 32, two bits
    prescale = 6'd32;
    repeat (2) tick();
    cnt_en = 1'b1;
    run_bit("t4", 32, 0, 1'b0, 1'b0, 0, 0, 32);
    run_bit("t4", 32, 1, 1'b1, 1'b1, 0, 0, 32);
    chk("t4 wrap bit_cnt", {28'd0, bit_cnt}, 32'd2);
    chk("t4 wrap edge_cnt", {26'd0, edge_cnt}, 32'd0);
    cnt_en = 1'b0;
    rx_in  = 1'b1;
    tick();

    // 5: cnt_en dropped at edge 5 discards the vote in progress
    prescale = 6'd8;
    tick();
    cnt_en = 1'b1;
    run_bit("t5", 8, 0, 1'b0, 1'b0, 0, 0, 5);
    chk("t5 edge before drop", {26'd0, edge_cnt}, 32'd5);
    cnt_en = 1'b0;
    tick();
    chk("t5 drop edge_cnt", {26'd0, edge_cnt}, 32'd0);
    chk("t5 drop bit_cnt", {28'd0, bit_cnt}, 32'd0);
    chk("t5 drop sample_valid", {31'd0, sample_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t5 idle%0d sample_valid", i), {31'd0, sample_valid}, 32'd0);
      chk($sformatf("t5 idle%0d edge_cnt", i), {26'd0, edge_cnt}, 32'd0);
    end
    chk("t5 sampled_bit hold", {31'd0, sampled_bit}, 32'd1);

    // 6: asynchronous reset in the middle of bit 4, then restart
    rx_in  = 1'b1;
    cnt_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      run_bit("t6", 8, b, t6_bits[b], t6_bits[b], 0, 0, 8);
    end
    run_bit("t6", 8, 4, 1'b0, 1'b0, 0, 0, 4);
    chk("t6 pre rx_sync", {31'd0, rx_sync}, 32'd0);
    chk("t6 pre sampled_bit", {31'd0, sampled_bit}, 32'd0);
    chk("t6 pre edge_cnt", {26'd0, edge_cnt}, 32'd4);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6 rst edge_cnt", {26'd0, edge_cnt}, 32'd0);
    chk("t6 rst bit_cnt", {28'd0, bit_cnt}, 32'd0);
    chk("t6 rst sampled_bit", {31'd0, sampled_bit}, 32'd1);
    chk("t6 rst sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("t6 rst rx_sync", {31'd0, rx_sync}, 32'd1);
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_bit("t6 restart", 8, 0, 1'b1, 1'b1, 0, 0, 8);
    run_bit("t6 restart", 8, 1, 1'b0, 1'b0, 0, 0, 8);
    cnt_en = 1'b0;
    rx_in  = 1'b1;
    tick();

    // 7: bit_cnt saturates at 15
    cnt_en = 1'b1;
    for (int b = 0; b < 18; b++) begin
      run_bit("t7", 8, (b > 15) ? 15 : b, 1'b1, 1'b1, 0, 0, 8);
    end
    chk("t7 saturated bit_cnt", {28'd0, bit_cnt}, 32'd15);
    cnt_en = 1'b0;
    tick();
    chk("t7 clear bit_cnt", {28'd0, bit_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
- UART RX front-end stage, directly upstream of the RX deserializer.
- Synchronises the raw serial line and counts oversampling edges and bit positions.
- Takes a 3-sample majority vote around each bit centre.
- Outputs sampled_bit, sample_valid and bit_cnt, which the deserializer consumes directly. The RX control FSM gates the block with cnt_en.

Parameters:
- PRESCALE_W, 6, width of the prescale input and of edge_cnt.
- BIT_CNT_W, 4, width of bit_cnt.

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- reset_n  input  1  asynchronous active-low reset
- rx_in  input  1  raw serial line, asynchronous to clk, idle high
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- cnt_en  input  1  from the RX FSM; high while a frame is being received
- edge_cnt  output  PRESCALE_W  oversample edge index within the current bit, 0..prescale-1
- bit_cnt  output  BIT_CNT_W  bit index within the frame; 0 = start bit, 1..8 = data bits
- sampled_bit  output  1  majority-voted value of the current bit
- sample_valid  output  1  one-cycle pulse; sampled_bit is valid for the current bit_cnt
- rx_sync  output  1  synchronised rx_in, used by the FSM for start-edge detection

Behaviour:
- Reset (asynchronous, active-low):
  - edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0.
  - Both synchroniser flops are set to 1, so rx_sync=1.
- Synchroniser:
  - rx_in passes through 2 flops to give rx_sync; latency 2 clk.
  - All sampling uses rx_sync, never rx_in.
- Counters when cnt_en=0:
  - edge_cnt and bit_cnt are cleared to 0 synchronously.
  - Internal vote registers are cleared; sample_valid=0.
  - sampled_bit holds its last value.
- Counters when cnt_en=1:
  - edge_cnt increments every clk.
  - When edge_cnt==prescale-1, edge_cnt wraps to 0 and bit_cnt increments.
  - bit_cnt saturates at 15 and does not wrap.
- Sampling, with mid = prescale>>1 (4, 8 or 16):
  - rx_sync is captured into s0, s1, s2 on the cycles where edge_cnt==mid-1, mid and mid+1 respectively.
  - On the cycle where edge_cnt==mid+2, sampled_bit is registered as maj(s0,s1,s2) = (s0&s1)|(s0&s2)|(s1&s2), and sample_valid is asserted in the same cycle.
  - So sample_valid is high for exactly one clk per bit, while edge_cnt==mid+3 and bit_cnt still equals the sampled bit's index. This alignment is mandatory because the deserializer indexes by bit_cnt-1 on sample_valid.
  - mid+3 < prescale holds for all legal prescale values (8 gives 7 < 8).
- Timing per bit: first vote sample at edge mid-1; sample_valid at edge mid+3.
- cnt_en deasserted mid-bit:
  - Counters clear on the next edge.
  - A vote in progress is discarded; no sample_valid is emitted.
  - If sample_valid was already registered for that cycle it still appears, because it is registered.
- cnt_en reasserted: counting restarts from edge 0, bit 0.
- prescale may change only while cnt_en=0. Illegal prescale values are unsupported; no error detection is required.
- Simultaneous wrap and sample: cannot occur for legal prescale values.
- Reset mid-frame: all outputs return to reset values immediately.

Decomposition:
- Shared package rx_pkg holds:
  - localparams PRESCALE_8/16/32;
  - BIT_CNT_START=0, BIT_CNT_LAST_DATA=8;
  - the function maj3(a,b,c).
- One sub-module: bit_sync, a 2-flop synchroniser with reset value 1, so it can be reused by other RX blocks.
- Edge/bit counters and the voter stay in rx_bit_sampler.

Test Plan:
1. Reset, then rx_in=1 and cnt_en=0 for 20 clk -> edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0, rx_sync=1.
2. prescale=8, cnt_en=1, frame 0 then 0xA5 LSB-first, then 1, each bit lasting 8 clk -> sample_valid pulses at edge_cnt=7 of bits 0..9; sampled_bit sequence 0,1,0,1,0,0,1,0,1,1; bit_cnt value at each pulse is 0..9.
3. prescale=16, with a one-clk glitch on a data bit at edge 8 (the centre) -> majority still gives the correct bit; a two-clk glitch covering edges 7-8 flips the bit.
4. prescale=32, run 2 bits -> sample_valid at edge_cnt=19 of each bit; bit_cnt increments after edge 31.
5. cnt_en dropped at edge_cnt=5, prescale=8 -> next clk edge_cnt=0, bit_cnt=0; no sample_valid for that bit.
6. reset_n asserted low mid-bit 4 -> all outputs go to reset values asynchronously; after release with cnt_en=1, counting restarts at edge 0, bit 0.
